// File: rtl/complex_pkg.sv
// Shared complex-sample types and helpers for the FFT datapath.
// complex_t is the default-width complex word {re, im}; blocks with a
// different component width declare their own packed [0:1][W-1:0] type.
package complex_pkg;

   localparam int CPLX_WIDTH = 32;

   // Complex sample: element 0 is the real part, element 1 the imaginary part.
   typedef logic signed [0:1][CPLX_WIDTH-1:0] complex_t;

   // Widest index that bitrev can reverse.
   localparam int BITREV_MAX_WIDTH = 32;

   // Reverse the low 'width' bits of 'value'. Bits above 'width' are ignored
   // and the result is zero above 'width'. Shared by the input and output
   // reorder blocks.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] result;
      logic [31:0] shifter;
      result  = '0;
      shifter = value;
      for (int i = 0; i < BITREV_MAX_WIDTH; i++) begin
         if (i < width) begin
            result = {result[30:0], shifter[0]};
         end
         shifter = shifter >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store for the output reorder buffer. One synchronous
// write port and one asynchronous read port; the top address bit selects
// the bank, the remaining bits the word within the bank.
module fft_pingpong_ram #(
   parameter int ADDR_W = 6,
   parameter int WIDTH  = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the incoming word on the clock edge it is accepted.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read is combinational so the top can register the word straight into
   // its output stage on the same edge the read counter advances.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer at the tail of the FFT pipeline. Frames arrive in
// bit-reversed order; each sample is written at the bit-reversed address of
// its arrival index so the reader can walk a bank linearly and emit natural
// order. Two banks ping-pong: one fills while the other drains through a
// ready/valid output register.
module fft_bitrev_reorder
   import complex_pkg::*;
#(
   parameter int N          = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic signed [0:1][DATA_WIDTH-1:0]  din,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic signed [0:1][DATA_WIDTH-1:0]  dout,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               overflow
);

   localparam int LOG2_N = $clog2(N);
   localparam int WORD_W = 2 * DATA_WIDTH;
   localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

   // Writer state
   logic              wr_bank_reg;
   logic [LOG2_N-1:0] wr_cnt_reg;
   logic              overflow_reg;

   // Reader state
   logic              rd_bank_reg;
   logic [LOG2_N-1:0] rd_cnt_reg;
   logic [WORD_W-1:0] dout_reg;
   logic              out_valid_reg;

   // Bank occupancy: set by the writer on frame completion, cleared by the
   // reader when the last word of the bank enters the output register.
   logic [1:0]        full_reg;
   logic [1:0]        full_next;

   logic              accept;
   logic              load;
   logic              wr_last;
   logic              rd_last;
   logic [LOG2_N-1:0] wr_addr_rev;
   logic [WORD_W-1:0] rd_word;

   // in_ready depends only on registered state, never on in_valid.
   assign in_ready    = !full_reg[wr_bank_reg];
   assign accept      = in_valid && in_ready;
   // The output register reloads when empty or being drained this edge.
   assign load        = (!out_valid_reg || out_ready) && full_reg[rd_bank_reg];
   assign wr_last     = accept && (wr_cnt_reg == LAST_IDX);
   assign rd_last     = load && (rd_cnt_reg == LAST_IDX);
   assign wr_addr_rev = LOG2_N'(bitrev(32'(wr_cnt_reg), LOG2_N));

   assign dout      = dout_reg;
   assign out_valid = out_valid_reg;
   assign overflow  = overflow_reg;

   fft_pingpong_ram #(
      .ADDR_W (LOG2_N + 1),
      .WIDTH  (WORD_W)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr ({wr_bank_reg, wr_addr_rev}),
      .wdata (din),
      .raddr ({rd_bank_reg, rd_cnt_reg}),
      .rdata (rd_word)
   );

   // Next full flags; writer and reader never finish the same bank on one
   // edge because a bank being written is never full.
   always_comb begin
      full_next = full_reg;
      if (wr_last) begin
         full_next[wr_bank_reg] = 1'b1;
      end
      if (rd_last) begin
         full_next[rd_bank_reg] = 1'b0;
      end
   end

   // Bank occupancy flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         full_reg <= 2'b00;
      end else begin
         full_reg <= full_next;
      end
   end

   // Writer: advance the arrival index, switch banks at frame end, and
   // latch a sticky flag for any sample offered while the bank is full.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_bank_reg  <= 1'b0;
         wr_cnt_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
            if (wr_last) begin
               wr_bank_reg <= !wr_bank_reg;
            end
         end
         if (in_valid && !in_ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Reader: move the next natural-order word into the output register,
   // or drop out_valid once the held word is taken and nothing is ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_bank_reg   <= 1'b0;
         rd_cnt_reg    <= '0;
         dout_reg      <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (load) begin
            dout_reg      <= rd_word;
            out_valid_reg <= 1'b1;
            rd_cnt_reg    <= rd_cnt_reg + 1'b1;
            if (rd_last) begin
               rd_bank_reg <= !rd_bank_reg;
            end
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the FFT output reorder buffer. An N=8 instance takes directed
// scenarios (ordering, latency, back-to-back, backpressure, reset); an N=32
// instance takes randomized valid/ready traffic. Both are scored against a
// frame model: output word a of a frame is the sample that arrived at index
// bitrev(a).
module tb_fft_bitrev_reorder;

   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic signed [0:1][DW-1:0] din8, dout8;
   logic in_valid8, in_ready8, out_valid8, out_ready8, overflow8;

   logic signed [0:1][DW-1:0] din32, dout32;
   logic in_valid32, in_ready32, out_valid32, out_ready32, overflow32;

   fft_bitrev_reorder #(.N(8), .DATA_WIDTH(DW)) dut8 (
      .clk(clk), .rst(rst), .din(din8), .in_valid(in_valid8), .in_ready(in_ready8),
      .dout(dout8), .out_valid(out_valid8), .out_ready(out_ready8), .overflow(overflow8)
   );

   fft_bitrev_reorder #(.N(32), .DATA_WIDTH(DW)) dut32 (
      .clk(clk), .rst(rst), .din(din32), .in_valid(in_valid32), .in_ready(in_ready32),
      .dout(dout32), .out_valid(out_valid32), .out_ready(out_ready32), .overflow(overflow32)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Index reversal computed arithmetically, independent of the RTL helper.
   function automatic int rev(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) begin
         r = r * 2 + ((v / (1 << i)) % 2);
      end
      return r;
   endfunction

   function automatic logic [63:0] mk(input int i);
      int ni;
      ni = -i;
      return {i[31:0], ni[31:0]};
   endfunction

   // ---------------- N=8 model ----------------
   logic [63:0] frm8[$];
   logic [63:0] exp8[$];
   logic [63:0] got8[$];
   int acc8, cons8, first_con8, last_con8;
   logic last_acc8, dropped8;

   task automatic step8(input logic v, input logic [63:0] d, input logic ordy);
      logic con;
      @(negedge clk);
      in_valid8  = v;
      din8       = d;
      out_ready8 = ordy;
      last_acc8  = v && in_ready8;
      con        = out_valid8 && ordy;
      if (v && !in_ready8) dropped8 = 1'b1;
      if (con) begin
         check("sb_has_data8", exp8.size() != 0, 1'b1);
         if (exp8.size() != 0) check("dout8", dout8, exp8.pop_front());
         got8.push_back(dout8);
         if (first_con8 < 0) first_con8 = cyc;
         last_con8 = cyc;
         cons8++;
      end
      if (last_acc8) begin
         frm8.push_back(d);
         acc8++;
         if (frm8.size() == 8) begin
            for (int a = 0; a < 8; a++) exp8.push_back(frm8[rev(a, 3)]);
            frm8.delete();
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain8(input int budget);
      int k;
      k = 0;
      while (exp8.size() != 0 && k < budget) begin
         step8(1'b0, 64'd0, 1'b1);
         k++;
      end
      check("drain8_done", exp8.size() == 0, 1'b1);
   endtask

   // ---------------- N=32 model ----------------
   logic [63:0] frm32[$];
   logic [63:0] exp32[$];
   int acc32, cons32;

   task automatic step32(input logic v, input logic [63:0] d, input logic ordy);
      logic acc, con;
      @(negedge clk);
      in_valid32  = v;
      din32       = d;
      out_ready32 = ordy;
      acc         = v && in_ready32;
      con         = out_valid32 && ordy;
      if (con) begin
         check("sb_has_data32", exp32.size() != 0, 1'b1);
         if (exp32.size() != 0) check("dout32", dout32, exp32.pop_front());
         cons32++;
      end
      if (acc) begin
         frm32.push_back(d);
         acc32++;
         if (frm32.size() == 32) begin
            for (int a = 0; a < 32; a++) exp32.push_back(frm32[rev(a, 5)]);
            frm32.delete();
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_models();
      frm8.delete(); exp8.delete(); got8.delete();
      frm32.delete(); exp32.delete();
      acc8 = 0; cons8 = 0; first_con8 = -1; last_con8 = -1;
      last_acc8 = 1'b0; dropped8 = 1'b0;
      acc32 = 0; cons32 = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; din8 = '0;
      in_valid32 = 1'b0; out_ready32 = 1'b0; din32 = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_models();
   endtask

   task automatic check_reset8(input string tag);
      check({tag, "_out_valid"}, out_valid8, 1'b0);
      check({tag, "_dout"},      dout8,      64'd0);
      check({tag, "_in_ready"},  in_ready8,  1'b1);
      check({tag, "_overflow"},  overflow8,  1'b0);
   endtask

   int tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   initial begin
      logic [31:0] re_e, im_e;
      int k;
      rst = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; din8 = '0;
      in_valid32 = 1'b0; out_ready32 = 1'b0; din32 = '0;
      clear_models();

      // Reset state
      do_reset();
      check_reset8("rst0");
      check("rst0_out_valid32", out_valid32, 1'b0);
      check("rst0_in_ready32",  in_ready32,  1'b1);

      // Single frame ordering and latency
      for (int i = 0; i < 8; i++) begin
         step8(1'b1, mk(i), 1'b1);
         if (i < 7) check("lat_early_valid", out_valid8, 1'b0);
      end
      check("lat_edge_k", out_valid8, 1'b0);
      step8(1'b0, 64'd0, 1'b1);
      check("lat_edge_k1", out_valid8, 1'b1);
      drain8(40);
      check("t1_count", got8.size(), 64'd8);
      for (int j = 0; j < 8 && j < got8.size(); j++) begin
         re_e = tbl[j];
         im_e = -re_e;
         check($sformatf("t1_order_%0d", j), got8[j], {re_e, im_e});
      end

      // Three back-to-back frames, including coincident bank completion
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step8(1'b1, mk(10 + i), 1'b1);
         if (acc8 == 16 && last_acc8) begin
            check("coinc_in_ready", in_ready8, 1'b1);
            check("coinc_out_valid", out_valid8, 1'b1);
         end
      end
      drain8(40);
      check("t2_count", cons8, 64'd24);
      check("t2_contiguous", last_con8 - first_con8, 64'd23);
      check("t2_no_drop", dropped8, 1'b0);
      check("t2_overflow", overflow8, 1'b0);

      // Backpressure: two frames plus one word held, then overflow
      do_reset();
      k = 0;
      while (acc8 < 16 && k < 24) begin
         step8(1'b1, mk(100 + k), 1'b0);
         k++;
      end
      check("bp_accepted", acc8, 64'd16);
      check("bp_in_ready_low", in_ready8, 1'b0);
      check("bp_out_valid", out_valid8, 1'b1);
      check("bp_overflow_pre", overflow8, 1'b0);
      step8(1'b1, mk(999), 1'b0);
      check("bp_17th_dropped", last_acc8, 1'b0);
      check("bp_overflow", overflow8, 1'b1);
      k = 0;
      while (exp8.size() != 0 && k < 40) begin
         step8(1'b0, 64'd0, 1'b1);
         check($sformatf("bp_bank0_free_c%0d", cons8), in_ready8, cons8 >= 7);
         k++;
      end
      check("bp_drained", cons8, 64'd16);
      check("bp_overflow_sticky", overflow8, 1'b1);

      // Reset mid-frame, and again while output is valid
      do_reset();
      for (int i = 0; i < 5; i++) step8(1'b1, mk(200 + i), 1'b1);
      do_reset();
      check_reset8("rst_mid");
      for (int i = 0; i < 8; i++) step8(1'b1, mk(300 + i), 1'b0);
      step8(1'b0, 64'd0, 1'b0);
      check("rst_pre_valid", out_valid8, 1'b1);
      do_reset();
      check_reset8("rst_valid");
      for (int i = 0; i < 8; i++) step8(1'b1, mk(400 + i), 1'b1);
      drain8(40);
      check("rst_post_count", cons8, 64'd8);
      for (int j = 0; j < 8 && j < got8.size(); j++) begin
         check($sformatf("rst_post_order_%0d", j), got8[j], mk(400 + tbl[j]));
      end

      // Randomized traffic on the N=32 instance, 10 frames
      do_reset();
      k = 0;
      while ((acc32 < 320 || cons32 < 320) && k < 6000) begin
         step32((acc32 < 320) && ($urandom_range(0, 3) != 0),
                {$urandom(), $urandom()},
                $urandom_range(0, 2) != 0);
         k++;
      end
      check("rnd_budget", k < 6000, 1'b1);
      check("rnd_accepted", acc32, 64'd320);
      check("rnd_consumed", cons32, 64'd320);
      check("rnd_sb_empty", exp32.size(), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Streaming output reorder buffer at the tail of the FFT pipeline. Consumes the bit-reversed-order sample stream produced by the last butterfly stage and emits each N-point frame in natural frequency order. It is built as a ping-pong pair of N-entry banks, so one frame is written while the previous frame is read. Unlike the butterfly stages, it adds an output ready/valid handshake, so a downstream consumer can apply backpressure.

## Interface
- N, 32: frame length in complex samples; power of two, ≥ 2.
- DATA_WIDTH, 32: width of each real/imag component.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- din  in  [0:1][DATA_WIDTH-1:0] signed  complex input sample {re, im}, bit-reversed frame order.
- in_valid  in  1  din valid this cycle.
- in_ready  out  1  bank space available; sample accepted on edge where in_valid && in_ready.
- dout  out  [0:1][DATA_WIDTH-1:0] signed  complex output sample, natural order.
- out_valid  out  1  dout holds a valid sample.
- out_ready  in  1  consumer accepts dout on edge where out_valid && out_ready.
- overflow  out  1  sticky; set when in_valid is high while in_ready is low.

## Operation
- Storage: 2 banks × N complex words, plus bank-state flags full[1:0].
- Writer: wr_bank (1 bit) and wr_cnt (LOG2_N bits).
  - On accept, write mem[wr_bank][bitrev(wr_cnt)] = din, then wr_cnt++.
  - When wr_cnt == N-1 is accepted: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- in_ready = !full[wr_bank]. This is combinational from registered state only; there is no path from in_valid.
- Dropped input: when in_valid && !in_ready, the sample is discarded, no state advances, and overflow is set. overflow stays set until reset.
- Reader: rd_bank (1 bit) and rd_cnt (LOG2_N bits). The output register {dout, out_valid} loads when it is empty or being consumed (!out_valid || out_ready).
  - If full[rd_bank], load dout = mem[rd_bank][rd_cnt], set out_valid = 1, rd_cnt++.
  - When rd_cnt == N-1 is loaded: clear full[rd_bank], toggle rd_bank, wrap rd_cnt.
  - If the bank is not full, out_valid drops to 0 when the held sample is consumed.
- Bank release happens on the edge the last word is loaded into the output register, not when that word is consumed.
- Simultaneous set and clear of the same full bit cannot occur, because the writer and reader always operate on different banks when both are active.
- Same-cycle bank completion by writer and reader is legal. Both updates take effect on that edge.
- Data passes through bit-exact; there is no arithmetic.

## Timing
- Reset values: dout = 0, out_valid = 0, overflow = 0, in_ready = 1. Counters, bank pointers and full flags are 0. Memory contents are not reset.
- Reset mid-frame discards all buffered and partial frames. The first sample after reset is treated as index 0 of a new frame.
- Latency: if edge k accepts input index N-1 of a frame and the reader is idle, edge k+1 loads output index 0, and out_valid is high from k+1.
- Throughput: 1 sample/cycle sustained with in_valid and out_ready held high. Input gaps and output stalls are tolerated at any point.
- With out_ready held low, at most 2 full frames plus 1 word in the output register are held. in_ready then goes low after the second frame completes.
- Bank-freed timing: after the edge that releases a bank, in_ready for that bank rises in the next cycle.

## Structure
- complex_pkg (existing) receives:
  - typedef complex_t = logic signed [0:1][DATA_WIDTH-1:0], parameterised via a package parameter or localparam wrapper;
  - function bitrev(value, width) for LOG2_N-bit reversal, shared with any future input-reorder block.
- localparam LOG2_N = $clog2(N) stays local.
- One sub-module: fft_pingpong_ram. It is a 2N-deep, one-write/one-read, asynchronous-read register array addressed by {bank, addr}. The counters, full flags and handshake stay in fft_bitrev_reorder.

## Test plan
- N=8, frame x_i = i (re = i, im = -i) streamed back-to-back, out_ready = 1 -> dout.re sequence 0,4,2,6,1,5,3,7 with matching im. out_valid is first high 1 cycle after the input index-7 edge.
- 3 back-to-back N=8 frames, out_ready = 1 -> 24 contiguous outputs, in_ready never drops, overflow = 0.
- out_ready = 0 while feeding frames -> in_ready falls after 16 accepted samples. A 17th in_valid sets overflow = 1. Raising out_ready then drains 16 correct samples, and in_ready returns high 1 cycle after bank 0 is released.
- Random in_valid gaps and random out_ready, 10 frames, N=32 -> scoreboard matches natural-order reference with no loss or duplication.
- Reset asserted after 5 of 8 inputs, and again while out_valid = 1 -> next cycle out_valid = 0, dout = 0, in_ready = 1. A following full frame reorders correctly from index 0.
- Last write into bank 1 on the same edge the reader loads word N-1 of bank 0 -> both full flags update correctly, and output continues with no bubble.
